// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the 32K x 8 asynchronous SRAM controller and its arbiter.
package mem_ctrl_pkg;

  localparam int SRAM_ADDR_W = 15;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_ACC,
    WR_ACC,
    HOLD
  } state_e;

  typedef enum logic {
    OWNER0 = 1'b0,
    OWNER1 = 1'b1
  } owner_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_arb2.sv
// Two-requester arbiter: fixed priority to requester 0 by default,
// round-robin on contention when MEM_ARB_RR_EN is defined.
module mem_arb2
  import mem_ctrl_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   req0_i,
  input  logic   req1_i,
  input  logic   grant_en_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  assign gnt_valid_o = req0_i | req1_i;

`ifdef MEM_ARB_RR_EN
  // ptr_q names the requester that wins the next contended grant.
  owner_e ptr_q, ptr_d;

  always_comb begin
    ptr_d       = ptr_q;
    gnt_owner_o = req1_i ? OWNER1 : OWNER0;
    if (req0_i && req1_i) begin
      gnt_owner_o = ptr_q;
      if (grant_en_i) begin
        ptr_d = (ptr_q == OWNER0) ? OWNER1 : OWNER0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= OWNER0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_arb;
  assign unused_arb  = ^{clk_i, rst_ni, grant_en_i};
  assign gnt_owner_o = (req0_i || !req1_i) ? OWNER0 : OWNER1;
`endif

endmodule

// File: rtl/sram32k_arb_ctrl.sv
// Two-port arbiter and access sequencer for a 32K x 8 asynchronous SRAM (active-low CS/OE/WE).
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module sram32k_arb_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] a_o,
  inout  wire  [DATA_W-1:0] io_io,
  output logic              cs_o,
  output logic              oe_o,
  output logic              we_o
);

  localparam int              CNT_W   = $clog2(max2(RD_WAIT, WR_WAIT) + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  owner_e              owner_q, owner_d;
  logic                op_we_q, op_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                gnt_valid;
  owner_e              gnt_owner;
  logic                accept;
  logic                drive_io;

  assign accept = (state_q == IDLE) && gnt_valid;

  mem_arb2 u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req0_i      (req0_i),
    .req1_i      (req1_i),
    .grant_en_i  (accept),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWNER0;
      op_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      op_we_q <= op_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    op_we_d = op_we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = SETUP;
          owner_d = gnt_owner;
          op_we_d = (gnt_owner == OWNER1) ? we1_i    : we0_i;
          addr_d  = (gnt_owner == OWNER1) ? addr1_i  : addr0_i;
          wdata_d = (gnt_owner == OWNER1) ? wdata1_i : wdata0_i;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = op_we_q ? WR_ACC : RD_ACC;
      end
      RD_ACC: begin
        // The SRAM output is sampled on the edge that closes the last wait cycle.
        if (cnt_q == RD_LAST) begin
          rdata_d = io_io;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_ACC: begin
        if (cnt_q == WR_LAST) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write data stays on the bus through HOLD to cover the SRAM data hold time.
  assign drive_io = op_we_q && ((state_q == SETUP) || (state_q == WR_ACC) || (state_q == HOLD));
  assign io_io    = drive_io ? wdata_q : {DATA_W{1'bz}};

  assign cs_o    = (state_q == IDLE);
  assign oe_o    = (state_q != RD_ACC);
  assign we_o    = (state_q != WR_ACC);
  assign busy_o  = (state_q != IDLE);
  assign a_o     = addr_q;
  assign rdata_o = rdata_q;
  assign ack0_o  = (state_q == HOLD) && (owner_q == OWNER0);
  assign ack1_o  = (state_q == HOLD) && (owner_q == OWNER1);

endmodule

// File: tb/tb_sram32k_arb_ctrl.sv
// Scoreboard bench for sram32k_arb_ctrl with a behavioural 32K x 8 SRAM on the IO bus.
// Define MEM_ARB_RR_EN to build the round-robin variant and its expectations.
module tb_sram32k_arb_ctrl;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int RW    = 2;
  localparam int WW    = 2;
  localparam int MEM_N = 1 << AW;

  typedef struct {
    bit            isWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            issueCyc;
    bit            checkLat;
  } txn_t;

  logic clk = 1'b0;
  logic rstN;
  logic req0, we0, ack0, req1, we1, ack1;
  logic [AW-1:0] addr0, addr1, a;
  logic [DW-1:0] wdata0, wdata1, rdata;
  logic busy, cs, oe, we;
  wire  [DW-1:0] io;

  logic [DW-1:0] memModel [MEM_N];
  logic [DW-1:0] refMem   [MEM_N];
  bit            refKnown [MEM_N];

  logic          preloadEn = 1'b0;
  logic [AW-1:0] preloadAddr = '0;
  logic [DW-1:0] preloadData = '0;

  txn_t pend0[$], pend1[$], sb0[$], sb1[$];
  txn_t cur0, cur1;
  int   ackOrder[$];
  int   cyc = 0;
  int   nCompared = 0;
  int   nFailed = 0;
  int   ackCnt0 = 0;
  int   ackCnt1 = 0;
  int   favour = 0;

  sram32k_arb_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_WAIT (RW),
    .WR_WAIT (WW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rstN),
    .req0_i   (req0),
    .we0_i    (we0),
    .addr0_i  (addr0),
    .wdata0_i (wdata0),
    .ack0_o   (ack0),
    .req1_i   (req1),
    .we1_i    (we1),
    .addr1_i  (addr1),
    .wdata1_i (wdata1),
    .ack1_o   (ack1),
    .rdata_o  (rdata),
    .busy_o   (busy),
    .a_o      (a),
    .io_io    (io),
    .cs_o     (cs),
    .oe_o     (oe),
    .we_o     (we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The SRAM drives the bus combinationally whenever it is selected for a read.
  assign io = (!cs && !oe && we) ? memModel[a] : {DW{1'bz}};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected winner when both requesters ask in the same IDLE cycle.
  function automatic int arbWinner();
    int w;
`ifdef MEM_ARB_RR_EN
    w      = favour;
    favour = 1 - w;
`else
    w = 0;
`endif
    return w;
  endfunction

  // Pops the owner's oldest issued request and applies it to the reference memory in completion order.
  task automatic retire(input int port);
    txn_t t;
    int   outstanding;
    ackOrder.push_back(port);
    outstanding = (port == 0) ? sb0.size() : sb1.size();
    checkOutput("ack_has_request", 32'(outstanding != 0), 32'd1);
    if (outstanding == 0) return;
    t = (port == 0) ? sb0.pop_front() : sb1.pop_front();
    checkOutput("ack_address", 32'(a), 32'(t.addr));
    if (t.isWrite) begin
      refMem[t.addr]   = t.data;
      refKnown[t.addr] = 1'b1;
    end else if (refKnown[t.addr]) begin
      checkOutput("read_data", 32'(rdata), 32'(refMem[t.addr]));
    end
    if (t.checkLat) begin
      checkOutput("ack_latency", 32'(cyc - t.issueCyc), 32'(2 + (t.isWrite ? WW : RW)));
    end
  endtask

  // Monitor: SRAM write/preload, bus invariants and ACK retirement, all on the falling edge.
  always @(negedge clk) begin
    if (preloadEn) begin
      memModel[preloadAddr] = preloadData;
      refMem[preloadAddr]   = preloadData;
      refKnown[preloadAddr] = 1'b1;
    end
    if (!cs && !we) begin
      memModel[a] = io;
      refKnown[a] = 1'b0;
    end
    if (rstN) begin
      checkOutput("oe_we_both_low", 32'(!oe && !we), 32'd0);
      checkOutput("busy_vs_idle", 32'(busy), 32'(!cs));
      checkOutput("ack_overlap", 32'(ack0 && ack1), 32'd0);
      if (!oe) checkOutput("io_during_read", 32'(io), 32'(memModel[a]));
      if (ack0) begin
        ackCnt0++;
        retire(0);
      end
      if (ack1) begin
        ackCnt1++;
        retire(1);
      end
    end
  end

  task automatic pushReq(input int port, input bit isWrite, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    t.isWrite  = isWrite;
    t.addr     = addr;
    t.data     = data;
    t.issueCyc = 0;
    t.checkLat = 1'b0;
    if (port == 0) pend0.push_back(t);
    else pend1.push_back(t);
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    preloadAddr = addr;
    preloadData = data;
    preloadEn   = 1'b1;
    @(negedge clk);
    #1;
    preloadEn   = 1'b0;
  endtask

  // Requester drivers: REQ drops (or moves to the next request) on the edge that ends its ACK cycle.
  task automatic applyStimulus(input int budget);
    int n = 0;
    bit active0 = 0, active1 = 0, new0, new1;
    int doneAt0 = 0, doneAt1 = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || active0 || active1) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      new0 = 0;
      new1 = 0;
      if (active0 && ackCnt0 >= doneAt0) begin
        active0 = 0;
        req0    = 1'b0;
      end
      if (active1 && ackCnt1 >= doneAt1) begin
        active1 = 0;
        req1    = 1'b0;
      end
      if (!active0 && pend0.size() != 0) begin
        cur0    = pend0.pop_front();
        req0    = 1'b1;
        we0     = cur0.isWrite;
        addr0   = cur0.addr;
        wdata0  = cur0.data;
        active0 = 1;
        new0    = 1;
        doneAt0 = ackCnt0 + 1;
      end
      if (!active1 && pend1.size() != 0) begin
        cur1    = pend1.pop_front();
        req1    = 1'b1;
        we1     = cur1.isWrite;
        addr1   = cur1.addr;
        wdata1  = cur1.data;
        active1 = 1;
        new1    = 1;
        doneAt1 = ackCnt1 + 1;
      end
      if (new0) begin
        cur0.issueCyc = cyc;
        cur0.checkLat = !busy && !req1;
        sb0.push_back(cur0);
      end
      if (new1) begin
        cur1.issueCyc = cyc;
        cur1.checkLat = !busy && !req0;
        sb1.push_back(cur1);
      end
    end
    checkOutput("traffic_drained", 32'(pend0.size() + pend1.size() + 32'(active0) + 32'(active1)), 32'd0);
  endtask

  function automatic logic [AW-1:0] randAddr();
    int r;
    r = $urandom_range(0, 15);
    return (r < 8) ? AW'(r) : AW'(32'h7FF0 + r);
  endfunction

  initial begin
    int base;
    rstN   = 1'b0;
    req0   = 1'b0;
    we0    = 1'b0;
    addr0  = '0;
    wdata0 = '0;
    req1   = 1'b0;
    we1    = 1'b0;
    addr1  = '0;
    wdata1 = '0;

    preload(15'h0000, 8'h11);
    preload(15'h0001, 8'h22);
    preload(15'h0002, 8'h33);

    checkOutput("reset_cs", 32'(cs), 32'd1);
    checkOutput("reset_oe", 32'(oe), 32'd1);
    checkOutput("reset_we", 32'(we), 32'd1);
    checkOutput("reset_addr", 32'(a), 32'd0);
    checkOutput("reset_ack", 32'({ack0, ack1}), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] write then read back on requester 0");
    pushReq(0, 1'b1, 15'h0123, 8'h5A);
    pushReq(0, 1'b0, 15'h0123, 8'h00);
    applyStimulus(200);
    checkOutput("t1_no_ack1", 32'(ackCnt1), 32'd0);

    $display("[TB] requester 1 back-to-back reads");
    pushReq(1, 1'b0, 15'h0000, 8'h00);
    pushReq(1, 1'b0, 15'h0001, 8'h00);
    pushReq(1, 1'b0, 15'h0002, 8'h00);
    applyStimulus(200);

    $display("[TB] contention, two rounds");
    for (int round = 0; round < 2; round++) begin
      base = ackOrder.size();
      pushReq(0, 1'b1, 15'h7FFF, 8'hA5);
      pushReq(1, 1'b0, 15'h0000, 8'h00);
      applyStimulus(200);
      checkOutput("contention_winner", (ackOrder.size() > base) ? 32'(ackOrder[base]) : 32'hFFFF_FFFF,
                  32'(arbWinner()));
    end

    $display("[TB] range ends");
    pushReq(0, 1'b1, 15'h0000, 8'hC3);
    pushReq(0, 1'b1, 15'h7FFF, 8'h3C);
    applyStimulus(200);
    pushReq(1, 1'b0, 15'h0000, 8'h00);
    pushReq(1, 1'b0, 15'h7FFF, 8'h00);
    applyStimulus(200);

    $display("[TB] randomized mixed traffic");
    for (int i = 0; i < 30; i++) begin
      pushReq(0, 1'($urandom_range(0, 1)), randAddr(), 8'($urandom));
      pushReq(1, 1'($urandom_range(0, 1)), randAddr(), 8'($urandom));
    end
    applyStimulus(2000);

    $display("[TB] reset during write access");
    @(posedge clk);
    #1;
    req0   = 1'b1;
    we0    = 1'b1;
    addr0  = 15'h0456;
    wdata0 = 8'h77;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("t5_we_low_before_reset", 32'(we), 32'd0);
    rstN = 1'b0;
    #1;
    checkOutput("t5_we_released", 32'(we), 32'd1);
    checkOutput("t5_cs_released", 32'(cs), 32'd1);
    checkOutput("t5_oe_high", 32'(oe), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_ack", 32'({ack0, ack1}), 32'd0);
    checkOutput("t5_addr", 32'(a), 32'd0);
    checkOutput("t5_rdata", 32'(rdata), 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t5_idle_after_release", 32'(busy), 32'd0);
    pushReq(0, 1'b0, 15'h0123, 8'h00);
    applyStimulus(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
